// File: rtl/nand_gate.sv
// rtl/nand_gate.sv - bitwise 2-input NAND with registered copy, self-check and truth-table coverage
module nand_gate #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   out_q,
    output logic [4*WIDTH-1:0] seen,
    output logic               cov_full,
    output logic               mismatch
);

    // Functional gate: never clocked, never gated, unaffected by reset
    assign out = ~(a & b);

    logic [4*WIDTH-1:0] w_hit;
    logic [4*WIDTH-1:0] r_seen;

    // One-hot decode of the {a,b} combination present on each lane
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_hit
            assign w_hit[g*4 + 0] = ~a[g] & ~b[g];
            assign w_hit[g*4 + 1] = ~a[g] &  b[g];
            assign w_hit[g*4 + 2] =  a[g] & ~b[g];
            assign w_hit[g*4 + 3] =  a[g] &  b[g];
        end
    endgenerate

    // Sticky coverage accumulation; reset wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen <= '0;
        end else begin
            r_seen <= r_seen | w_hit;
        end
    end

    assign seen     = r_seen;
    assign cov_full = &r_seen;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] r_out_q;
            logic [WIDTH-1:0] r_chk;
            logic             r_mismatch;

            // Registered copy of out; all-ones is the NAND of idle 00 inputs
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out_q <= '1;
                end else begin
                    r_out_q <= out;
                end
            end

            // Reference register built through De Morgan so it does not share the out path
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_chk <= '1;
                end else begin
                    r_chk <= ~a | ~b;
                end
            end

            // Sticky flag raised on any disagreement between out_q and the reference
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mismatch <= 1'b0;
                end else if (r_out_q != r_chk) begin
                    r_mismatch <= 1'b1;
                end
            end

            assign out_q    = r_out_q;
            assign mismatch = r_mismatch;
        end else begin : g_noreg
            assign out_q    = '1;
            assign mismatch = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_nand_gate.sv
// tb/tb_nand_gate.sv - self-checking bench for nand_gate, WIDTH=1 and WIDTH=4 instances
`timescale 1ns/1ps
module tb_nand_gate;

    logic       clk = 1'b0;
    logic       reset;
    logic       a1, b1;
    logic       out1, out_q1, cov_full1, mismatch1;
    logic [3:0] seen1;
    logic [3:0] a4, b4, out4, out_q4;
    logic [15:0] seen4;
    logic       cov_full4, mismatch4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand_gate #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1),
        .out(out1), .out_q(out_q1), .seen(seen1),
        .cov_full(cov_full1), .mismatch(mismatch1)
    );

    nand_gate #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4),
        .out(out4), .out_q(out_q4), .seen(seen4),
        .cov_full(cov_full4), .mismatch(mismatch4)
    );

    typedef struct {
        logic a;
        logic b;
        logic exp;
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec4_t;

    vec1_t tt1[4];
    vec4_t tt4[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ra, rb, rexp, prev_exp;

        tt1[0] = '{1'b0, 1'b0, 1'b1};
        tt1[1] = '{1'b0, 1'b1, 1'b1};
        tt1[2] = '{1'b1, 1'b0, 1'b1};
        tt1[3] = '{1'b1, 1'b1, 1'b0};

        tt4[0] = '{4'b1100, 4'b1010, 4'b0111};
        tt4[1] = '{4'b0000, 4'b1111, 4'b1111};
        tt4[2] = '{4'b1111, 4'b1111, 4'b0000};
        tt4[3] = '{4'b0101, 4'b0110, 4'b1011};

        reset = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'b0; b4 = 4'b0;

        // Combinational truth table
        for (int i = 0; i < 4; i++) begin
            a1 = tt1[i].a;
            b1 = tt1[i].b;
            #1;
            chk($sformatf("tt1_out[%0d]", i), {31'b0, out1}, {31'b0, tt1[i].exp});
        end
        for (int i = 0; i < 4; i++) begin
            a4 = tt4[i].a;
            b4 = tt4[i].b;
            #1;
            chk($sformatf("tt4_out[%0d]", i), {28'b0, out4}, {28'b0, tt4[i].exp});
        end

        // Reset held for two cycles
        @(negedge clk);
        reset = 1'b1; a1 = 1'b0; b1 = 1'b0; a4 = 4'b0; b4 = 4'b0;
        edge_then_settle();
        edge_then_settle();
        chk("rst_out_q",    {31'b0, out_q1},    32'd1);
        chk("rst_seen",     {28'b0, seen1},     32'd0);
        chk("rst_cov_full", {31'b0, cov_full1}, 32'd0);
        chk("rst_mismatch", {31'b0, mismatch1}, 32'd0);
        chk("rst_out_q4",   {28'b0, out_q4},    32'hF);
        chk("rst_seen4",    {16'b0, seen4},     32'd0);

        // out follows inputs during reset; reset beats the 11 coverage set
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1;
        #1;
        chk("rst_out_tracks", {31'b0, out1}, 32'd0);
        edge_then_settle();
        chk("rst_out_q_held", {31'b0, out_q1}, 32'd1);
        chk("rst_seen_prio",  {28'b0, seen1},  32'd0);

        // Latency: 11 before edge N, then 01 before edge N+1
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("lat_out_imm", {31'b0, out1}, 32'd0);
        edge_then_settle();
        chk("lat_out_q_n",  {31'b0, out_q1}, 32'd0);
        chk("lat_seen_n",   {28'b0, seen1},  32'b1000);
        @(negedge clk);
        a1 = 1'b0;
        #1;
        chk("lat_out_rise",   {31'b0, out1},   32'd1);
        chk("lat_out_q_hold", {31'b0, out_q1}, 32'd0);
        edge_then_settle();
        chk("lat_out_q_n1", {31'b0, out_q1}, 32'd1);
        chk("lat_seen_n1",  {28'b0, seen1},  32'b1010);

        // Coverage stepping from a clean reset
        @(negedge clk);
        reset = 1'b1; a1 = 1'b0; b1 = 1'b0;
        edge_then_settle();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_seen;
            exp_seen = 4'((1 << (i + 1)) - 1);
            a1 = tt1[i].a;
            b1 = tt1[i].b;
            edge_then_settle();
            chk($sformatf("cov_seen[%0d]", i), {28'b0, seen1}, {28'b0, exp_seen});
            chk($sformatf("cov_full[%0d]", i), {31'b0, cov_full1}, (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("cov_mismatch", {31'b0, mismatch1}, 32'd0);
        reset = 1'b1; a1 = 1'b1; b1 = 1'b1;
        edge_then_settle();
        chk("cov_rst_seen", {28'b0, seen1},     32'd0);
        chk("cov_rst_full", {31'b0, cov_full1}, 32'd0);

        // WIDTH=4 lanes: directed vector then 1000 random vectors
        @(negedge clk);
        reset = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        chk("w4_out", {28'b0, out4}, 32'b0111);
        edge_then_settle();
        chk("w4_out_q", {28'b0, out_q4}, 32'b0111);
        prev_exp = 4'b0111;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rexp = 4'b0;
            for (int k = 0; k < 4; k++) rexp[k] = !(ra[k] && rb[k]);
            a4 = ra; b4 = rb;
            #1;
            chk("rnd_out", {28'b0, out4}, {28'b0, rexp});
            chk("rnd_out_q_prev", {28'b0, out_q4}, {28'b0, prev_exp});
            edge_then_settle();
            chk("rnd_out_q", {28'b0, out_q4}, {28'b0, rexp});
            prev_exp = rexp;
        end
        edge_then_settle();
        chk("rnd_mismatch", {31'b0, mismatch4}, 32'd0);
        chk("rnd_cov_full", {31'b0, cov_full4}, 32'd1);
        chk("rnd_seen4",    {16'b0, seen4},     32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
